// File: rtl/or_result_fifo.sv
// or_result_fifo: FIFO for or4 result words with a latency of one cycle.
// It also keeps a sticky bitwise-OR accumulator over every word it accepts.
module or_result_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [WIDTH-1:0]       in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    input  logic                   acc_clr,
    output logic [WIDTH-1:0]       acc,
    output logic                   acc_full,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0]    rd_ptr_reg, rd_ptr_next;
    logic [LW-1:0]    level_reg, level_next;
    logic [WIDTH-1:0] acc_reg, acc_next;
    logic             push;
    logic             pop;

    // Handshake flags come only from level_reg, so out_ready cannot reach in_ready.
    assign in_ready  = (level_reg < FULL_LEVEL);
    assign out_valid = (level_reg != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        level_next  = level_reg;
        if (push) begin
            wr_ptr_next = wr_ptr_reg + 1'b1;
        end
        if (pop) begin
            rd_ptr_next = rd_ptr_reg + 1'b1;
        end
        case ({push, pop})
            2'b10:   level_next = level_reg + 1'b1;
            2'b01:   level_next = level_reg - 1'b1;
            default: level_next = level_reg;
        endcase
    end

    // The clear takes effect before the incoming word is merged in.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_acc_bit
            assign acc_next[gi] = acc_clr ? (push & in_data[gi])
                                          : (acc_reg[gi] | (push & in_data[gi]));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
            acc_reg    <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            level_reg  <= level_next;
            acc_reg    <= acc_next;
        end
    end

    assign out_data = out_valid ? mem[rd_ptr_reg] : '0;
    assign acc      = acc_reg;
    assign acc_full = &acc_reg;
    assign level    = level_reg;

endmodule
